// File: rtl/fmul_arb_pkg.sv
// fmul_arb_pkg: shared constants and FSM state type for the multiplier arbiter
package fmul_arb_pkg;
    localparam int FP_W     = 32;
    localparam int NREQ_DEF = 4;
    typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, WAIT_Z, RESP} state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin pick of the first request at or after ptr
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);
    logic [IW-1:0] c;
    // Walk offsets from farthest to nearest so the nearest request wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        c     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            c = IW'((int'(ptr) + i) % N);
            if (req[c]) begin
                grant    = '0;
                grant[c] = 1'b1;
                idx      = c;
            end
        end
    end
endmodule

// File: rtl/fmul_arbiter.sv
// fmul_arbiter: round-robin arbiter sharing one strobe/ack FP multiplier among NREQ requesters
module fmul_arbiter
    import fmul_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0][FP_W-1:0] req_a,
    input  logic [NREQ-1:0][FP_W-1:0] req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [FP_W-1:0]      rsp_z,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [FP_W-1:0]      mul_a,
    output logic                 mul_a_stb,
    input  logic                 mul_a_ack,
    output logic [FP_W-1:0]      mul_b,
    output logic                 mul_b_stb,
    input  logic                 mul_b_ack,
    input  logic [FP_W-1:0]      mul_z,
    input  logic                 mul_z_stb,
    output logic                 mul_z_ack,
    output logic [15:0]          ops_done
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    state_t state, state_n;
    logic [IW-1:0] rr_ptr, gidx, pick_idx;
    logic [NREQ-1:0] pick_grant;
    logic [FP_W-1:0] a_q, b_q;
    rr_pick #(.N(NREQ), .IW(IW)) u_pick (
        .req  (req_valid),
        .ptr  (rr_ptr),
        .grant(pick_grant),
        .idx  (pick_idx)
    );
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    state_n = |req_valid ? SEND_A : IDLE;
            SEND_A:  state_n = mul_a_ack ? SEND_B : SEND_A;
            SEND_B:  state_n = mul_b_ack ? WAIT_Z : SEND_B;
            WAIT_Z:  state_n = mul_z_stb ? RESP : WAIT_Z;
            RESP:    state_n = rsp_ready[gidx] ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end
    // No accept pulse while reset is held, so nothing is granted and then dropped.
    assign req_ready = (state == IDLE && !rst) ? pick_grant : '0;
    assign rsp_valid = (state == RESP) ? NREQ'(1) << gidx : '0;
    assign mul_a_stb = state == SEND_A;
    assign mul_b_stb = state == SEND_B;
    assign mul_z_ack = state == WAIT_Z;
    assign mul_a     = a_q;
    assign mul_b     = b_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            ops_done <= '0;
            rsp_z    <= '0;
            gidx     <= '0;
            a_q      <= '0;
            b_q      <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && |req_valid) begin
                gidx <= pick_idx;
                a_q  <= req_a[pick_idx];
                b_q  <= req_b[pick_idx];
            end
            if (state == WAIT_Z && mul_z_stb) rsp_z <= mul_z;
            if (state == RESP && rsp_ready[gidx]) begin
                ops_done <= ops_done + 16'd1;
                rr_ptr   <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
            end
        end
    end
endmodule

// File: doc/fmul_arbiter.md
FMUL_ARBITER -- requirements
Module: fmul_arbiter

Interface
REQ-001 The block SHALL have parameter: NREQ, 4, number of requesters sharing one multiplier (2..8).
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 The block SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-004 The block SHALL have port: rst  input  1  synchronous active-high reset, also wired to the shared multiplier.
REQ-005 The block SHALL have port: req_valid  input  NREQ  per-requester operation request.
REQ-006 The block SHALL have port: req_a  input  NREQ x 32  per-requester IEEE-754 single operand A.
REQ-007 The block SHALL have port: req_b  input  NREQ x 32  per-requester IEEE-754 single operand B.
REQ-008 The block SHALL have port: req_ready  output  NREQ  one-hot, one-cycle accept pulse.
REQ-009 The block SHALL have port: rsp_valid  output  NREQ  one-hot result-valid to the granted requester.
REQ-010 The block SHALL have port: rsp_z  output  32  product; valid while any rsp_valid bit is high.
REQ-011 The block SHALL have port: rsp_ready  input  NREQ  per-requester result acceptance.
REQ-012 The block SHALL have port group mul_a/mul_a_stb/mul_a_ack, mul_b/mul_b_stb/mul_b_ack, mul_z/mul_z_stb/mul_z_ack: 32/1/1 bits each, driving the multiplier's strobe/ack ports.
REQ-013 The block SHALL have port: ops_done  output  16  count of completed operations.

Function
REQ-014 FSM states SHALL be: IDLE, SEND_A, SEND_B, WAIT_Z, RESP.
REQ-015 In IDLE with any req_valid high, the block SHALL grant the first requester at or after rr_ptr (wrapping), pulse req_ready[g] for one cycle, latch req_a[g]/req_b[g] and g, and enter SEND_A.
REQ-016 SEND_A SHALL hold mul_a_stb=1 and mul_a stable until mul_a_stb && mul_a_ack is sampled high; it SHALL then drop mul_a_stb the next cycle and enter SEND_B.
REQ-017 SEND_B SHALL behave the same with mul_b_stb/mul_b_ack and then enter WAIT_Z.
REQ-018 WAIT_Z SHALL hold mul_z_ack=1; on mul_z_stb && mul_z_ack, it SHALL latch mul_z into rsp_z, drop mul_z_ack the next cycle, and enter RESP.
REQ-019 RESP SHALL hold rsp_valid[g]=1 and rsp_z stable until rsp_ready[g]; on that edge it SHALL increment ops_done, set rr_ptr=(g+1) mod NREQ, and return to IDLE.
REQ-020 The block SHALL never assert more than one of req_ready, rsp_valid, or mul_*_stb in the same cycle.
REQ-021 Requests arriving outside IDLE SHALL be ignored until IDLE; req_valid dropped before grant SHALL be legal.
REQ-022 The block SHALL add a latency of exactly one cycle in IDLE; it SHALL NOT pipeline; one operation is in flight at most.
REQ-023 ops_done SHALL wrap from 0xFFFF to 0x0000.
REQ-024 rsp_ready for a non-granted requester SHALL be ignored.
REQ-025 The result SHALL be passed unmodified; NaN/Inf/denormal handling SHALL remain the multiplier's.

Reset
REQ-026 On rst=1, at the edge, the block SHALL enter IDLE and clear rr_ptr, ops_done, req_ready, rsp_valid, mul_a_stb, mul_b_stb, and mul_z_ack; rsp_z SHALL become 0.
REQ-027 A reset in any state SHALL abandon the in-flight operation silently with no response, and the multiplier SHALL be reset by the same rst.

Structure
REQ-028 Package fmul_arb_pkg SHALL hold the FP_W=32 constant, the NREQ default, and the state enum type.
REQ-029 Round-robin selection SHALL live in sub-module rr_pick (inputs: req vector and pointer; outputs: one-hot grant and index; combinational).

Verification
REQ-030 Single op: req 0 sends 0x40000000 × 0x40400000 -> rsp_valid[0] with rsp_z=0x40C00000; ops_done=1.
REQ-031 All four req_valid asserted at once with rr_ptr=0 -> grants in order 0,1,2,3, each with a correct product; ops_done=4.
REQ-032 Inf × 0 (0x7F800000 × 0x00000000) on req 2 -> rsp_z=0xFFC00000.
REQ-033 rsp_ready[1] held low for 20 cycles -> rsp_valid[1] and rsp_z stay stable, no new req_ready; completion on the first rsp_ready[1].
REQ-034 rst asserted in WAIT_Z -> next cycle IDLE with all outputs 0; a subsequent op 1.0×1.0 (0x3F800000) returns 0x3F800000.
REQ-035 Preload ops_done to 0xFFFF via 65535 ops (or force) -> the next completion gives 0x0000.
